// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the request arbiter.
package arb_pkg;

    localparam int NUM_REQ = 8;
    localparam int ID_W    = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/prio_enc8.sv
// Combinational 8-input priority encoder: returns the highest set index.
module prio_enc8
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] vec,
    output logic [ID_W-1:0]    idx,
    output logic               valid
);

    always_comb begin
        // NOTE: default before the loop keeps every path assigned, so no latch is inferred.
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (vec[i]) idx = ID_W'(i);
        end
    end

    assign valid = |vec;

endmodule

// File: rtl/req_arbiter.sv
// Eight-way grant/hold arbiter with a hold-time limit.
// Define REQ_ARBITER_RR_EN for round-robin arbitration; fixed priority otherwise.
module req_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               busy,
    output logic               timeout
);

    localparam int CNT_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

`ifdef REQ_ARBITER_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    state_t             state;
    logic [CNT_W-1:0]   hold_cnt;
    logic [ID_W-1:0]    last_id;
    logic [ID_W-1:0]    rot_amt;
    logic [ID_W-1:0]    enc_idx;
    logic [ID_W-1:0]    win_id;
    logic               enc_valid;
    logic [NUM_REQ-1:0] rot_req;
    logic               release_hold;

    // Rotating by last_id puts index last_id-1 at the top, so the encoder scans
    // downward from there and wraps; a zero rotation is plain fixed priority.
    assign rot_amt = RR_EN ? last_id : '0;

    always_comb begin
        rot_req = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            logic [ID_W-1:0] src;
            src        = ID_W'(i) + rot_amt;
            rot_req[i] = req[src];
        end
    end

    prio_enc8 u_prio_enc8 (
        .vec   (rot_req),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    assign win_id       = enc_idx + rot_amt;
    assign release_hold = done | ~|(req & grant);
    assign busy         = (state == HOLD);

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register updates from pre-edge values.
        if (rst) begin
            state    <= IDLE;
            grant    <= '0;
            grant_id <= '0;
            timeout  <= 1'b0;
            hold_cnt <= '0;
            last_id  <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (enc_valid) begin
                        state    <= HOLD;
                        grant    <= NUM_REQ'(1) << win_id;
                        grant_id <= win_id;
                        last_id  <= win_id;
                        hold_cnt <= '0;
                    end
                end
                HOLD: begin
                    // A dropped request counts as done, and done beats the hold limit.
                    if (release_hold) begin
                        state    <= IDLE;
                        grant    <= '0;
                        grant_id <= '0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state    <= IDLE;
                        grant    <= '0;
                        grant_id <= '0;
                        timeout  <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_req_arbiter.sv
// Scoreboard bench for req_arbiter: directed scenarios plus random traffic
// against a behavioural owner/hold-time model.
module tb_req_arbiter;

    localparam int MAX_HOLD = 4;
`ifdef REQ_ARBITER_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] grant;
        logic [2:0] gid;
        logic       busy;
        logic       timeout;
        logic [2:0] last;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = '0;
    logic       done = 1'b0;
    logic [7:0] grant;
    logic [2:0] grant_id;
    logic       busy;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    obs_t exp_q[$];

    // Reference model: who owns the resource, how many cycles it has held it.
    int m_owner = -1;
    int m_held  = 0;
    int m_last  = 0;
    bit m_to    = 1'b0;

    req_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .done     (done),
        .grant    (grant),
        .grant_id (grant_id),
        .busy     (busy),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic int pick(input logic [7:0] q, input int last);
        int start;
        int idx;
        start = RR ? (last + 7) % 8 : 7;
        for (int k = 0; k < 8; k++) begin
            idx = (start - k + 8) % 8;
            if (q[idx]) return idx;
        end
        return -1;
    endfunction

    // Apply one cycle of inputs, advance the model, queue the expected outputs.
    task automatic drive(input logic r, input logic [7:0] q, input logic d);
        obs_t e;
        rst  = r;
        req  = q;
        done = d;
        if (r) begin
            m_owner = -1;
            m_held  = 0;
            m_last  = 0;
            m_to    = 1'b0;
        end else if (m_owner < 0) begin
            m_to = 1'b0;
            m_owner = pick(q, m_last);
            if (m_owner >= 0) begin
                m_held = 1;
                m_last = m_owner;
            end
        end else if (d || !q[m_owner]) begin
            m_owner = -1;
            m_to    = 1'b0;
        end else if (m_held == MAX_HOLD) begin
            m_owner = -1;
            m_to    = 1'b1;
        end else begin
            m_held++;
        end
        e.grant   = (m_owner < 0) ? 8'h00 : 8'(1 << m_owner);
        e.gid     = (m_owner < 0) ? 3'd0 : 3'(m_owner);
        e.busy    = (m_owner >= 0);
        e.timeout = m_to;
        e.last    = 3'(m_last);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: the DUT presents outputs every cycle; compare just after each edge.
    initial begin
        obs_t e;
        obs_t a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{grant, grant_id, busy, timeout, dut.last_id};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL sb at %0t: got grant=%h id=%0d busy=%b to=%b last=%0d expected grant=%h id=%0d busy=%b to=%b last=%0d",
                             $time, a.grant, a.gid, a.busy, a.timeout, a.last,
                             e.grant, e.gid, e.busy, e.timeout, e.last);
                end
            end
        end
    end

    initial begin
        logic [7:0] rq;
        logic       rr;
        logic       dd;

        // Reset with requests pending must not grant.
        drive(1'b1, 8'hFF, 1'b0);
        drive(1'b1, 8'hFF, 1'b0);
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);

        // Fixed-priority pick and release.
        drive(1'b0, 8'b0010_0101, 1'b0);
        check("fp_grant", 32'(grant), 32'h20);
        check("fp_id", 32'(grant_id), 32'd5);
        check("fp_busy", 32'(busy), 32'h1);
        drive(1'b0, 8'b0010_0101, 1'b0);
        check("hold_stable", 32'(grant), 32'h20);
        drive(1'b0, 8'b0010_0101, 1'b1);
        check("rel_grant", 32'(grant), 32'h0);
        check("rel_busy", 32'(busy), 32'h0);
        drive(1'b0, 8'b0000_0101, 1'b0);
        check("rel_next_grant", 32'(grant), 32'h04);
        check("rel_next_id", 32'(grant_id), 32'd2);
        drive(1'b0, 8'h00, 1'b0);
        check("drop_release", 32'(grant), 32'h0);

        // done while idle is ignored.
        drive(1'b0, 8'h00, 1'b1);
        check("idle_done", 32'(busy), 32'h0);

        // Hold limit: four cycles of grant, then a single timeout pulse.
        drive(1'b1, 8'h00, 1'b0);
        for (int n = 0; n < MAX_HOLD; n++) begin
            drive(1'b0, 8'h80, 1'b0);
            check("to_held", 32'(grant), 32'h80);
            check("to_nopulse", 32'(timeout), 32'h0);
        end
        drive(1'b0, 8'h80, 1'b0);
        check("to_grant", 32'(grant), 32'h0);
        check("to_pulse", 32'(timeout), 32'h1);
        drive(1'b0, 8'h80, 1'b0);
        check("to_pulse_end", 32'(timeout), 32'h0);
        check("to_regrant", 32'(grant), 32'h80);
        drive(1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 1'b0);

        // done in the limit cycle wins over the timeout.
        for (int n = 0; n < MAX_HOLD; n++) drive(1'b0, 8'h80, 1'b0);
        drive(1'b0, 8'h80, 1'b1);
        check("dt_grant", 32'(grant), 32'h0);
        check("dt_timeout", 32'(timeout), 32'h0);
        drive(1'b0, 8'h00, 1'b0);

        // Saturated requests with done every grant.
        drive(1'b1, 8'h00, 1'b0);
        for (int n = 0; n < 9; n++) begin
            drive(1'b0, 8'hFF, 1'b0);
            check("seq_id", 32'(grant_id), RR ? 32'((15 - n) % 8) : 32'd7);
            drive(1'b0, 8'hFF, 1'b1);
        end

        // Reset during a hold abandons the grant.
        drive(1'b0, 8'h80, 1'b0);
        drive(1'b0, 8'h80, 1'b0);
        drive(1'b1, 8'h80, 1'b0);
        check("mr_grant", 32'(grant), 32'h0);
        check("mr_busy", 32'(busy), 32'h0);
        check("mr_timeout", 32'(timeout), 32'h0);
        check("mr_last", 32'(dut.last_id), 32'h0);
        drive(1'b0, 8'h03, 1'b0);
        check("mr_first_id", 32'(grant_id), 32'd1);
        drive(1'b0, 8'h00, 1'b0);

        // Random traffic with sticky requests so holds and timeouts occur.
        rq = 8'h00;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 7) == 0)
                rq = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            rr = ($urandom_range(0, 99) == 0);
            dd = ($urandom_range(0, 5) == 0);
            drive(rr, rq, dd);
        end
        drive(1'b0, 8'h00, 1'b0);

        @(posedge clk);
        #2;
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
